// File: rtl/fa_bist_ctrl.sv
// rtl/fa_bist_ctrl.sv - exhaustive-vector self-test controller for a 1-bit full adder
module fa_bist_ctrl #(
    parameter int NUM_VEC    = 8,
    parameter int SETTLE_CYC = 2,
    parameter int ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    output logic             dut_c,
    input  logic             dut_s,
    input  logic             dut_carry,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] fail_cnt,
    output logic             fail_valid,
    output logic [2:0]       first_fail_idx
);

    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [2:0]    IDX_LAST    = 3'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [2:0]      idx;
    logic [SW-1:0]   settle_cnt;
    logic            exp_s;
    logic            exp_c;
    logic            mismatch;
    logic [ERR_W-1:0] cnt_inc;

    // Golden values come from the registered stimulus, so the compare sees settled inputs.
    assign exp_s    = dut_a ^ dut_b ^ dut_c;
    assign exp_c    = (dut_a & dut_b) | (dut_a & dut_c) | (dut_b & dut_c);
    assign mismatch = (dut_s != exp_s) || (dut_carry != exp_c);
    assign cnt_inc  = (fail_cnt == {ERR_W{1'b1}}) ? fail_cnt : fail_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            idx            <= '0;
            settle_cnt     <= '0;
            dut_a          <= 1'b0;
            dut_b          <= 1'b0;
            dut_c          <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_cnt       <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_APPLY;
                        idx            <= '0;
                        fail_cnt       <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_idx <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                S_APPLY: begin
                    dut_a      <= idx[0];
                    dut_b      <= idx[1];
                    dut_c      <= idx[2];
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        fail_cnt <= cnt_inc;
                        if (!fail_valid) begin
                            fail_valid     <= 1'b1;
                            first_fail_idx <= idx;
                        end
                    end
                    if (idx == IDX_LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Last vector's verdict is folded in here since fail_cnt updates on this same edge.
                        pass  <= (fail_cnt == '0) && !mismatch;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
